// File: rtl/iir_cascade.sv
// Cascade of Direct Form I biquads, one pipeline register per stage, full-precision
// accumulation with half-up rounding. Define IIR_STAGE_SAT_EN for per-stage saturation (wraps otherwise).

module round_handle #(
  parameter int IW    = 43,
  parameter int SHIFT = 14
) (
  input  logic signed [IW-1:0]       acc,
  output logic signed [IW-SHIFT-1:0] rnd
);
  localparam logic signed [IW-1:0] HALF_C = {{(IW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  logic signed [IW-1:0] sum_s;
  logic                 unused_frac_s;

  assign sum_s         = acc + HALF_C;
  assign rnd           = sum_s[IW-1:SHIFT];
  assign unused_frac_s = ^sum_s[SHIFT-1:0];
endmodule

module sat_handle #(
  parameter int IW = 29,
  parameter int OW = 24
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout
);
  localparam logic signed [IW-1:0] MAX_C = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_C = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // clamp to the signed output range
  always_comb begin
    dout = din[OW-1:0];
    if (din > MAX_C) begin
      dout = MAX_C[OW-1:0];
    end else if (din < MIN_C) begin
      dout = MIN_C[OW-1:0];
    end else begin
      dout = din[OW-1:0];
    end
  end
endmodule

module iir_cascade #(
  parameter int CASCADE_LEVEL = 2,
  parameter int DWIDTH        = 24,
  parameter int CWIDTH        = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              block_en,
  input  logic [CASCADE_LEVEL*5*CWIDTH-1:0] coefs,
  input  logic                              din_vld,
  input  logic [DWIDTH-1:0]                 din,
  output logic [DWIDTH-1:0]                 dout
);
  localparam int ACC_W = DWIDTH + CWIDTH + 3;
  localparam int SHIFT = CWIDTH - 2;
  localparam int RND_W = ACC_W - SHIFT;

  logic signed [DWIDTH-1:0] x1_r  [CASCADE_LEVEL];
  logic signed [DWIDTH-1:0] x2_r  [CASCADE_LEVEL];
  logic signed [DWIDTH-1:0] y1_r  [CASCADE_LEVEL];
  logic signed [DWIDTH-1:0] y2_r  [CASCADE_LEVEL];
  logic signed [DWIDTH-1:0] xin_s [CASCADE_LEVEL];
  logic signed [DWIDTH-1:0] yn_s  [CASCADE_LEVEL];
  logic [CASCADE_LEVEL-1:0] vld_r;
  logic [CASCADE_LEVEL-1:0] vin_s;
  logic                     unused_vld_s;

  function automatic logic signed [ACC_W-1:0] mul(input logic signed [CWIDTH-1:0] c,
                                                  input logic signed [DWIDTH-1:0] d);
    logic signed [ACC_W-1:0] ce_s;
    logic signed [ACC_W-1:0] de_s;
    ce_s = ACC_W'(c);
    de_s = ACC_W'(d);
    return ce_s * de_s;
  endfunction

  for (genvar k = 0; k < CASCADE_LEVEL; k++) begin : g_stage
    logic signed [CWIDTH-1:0] b0_s, b1_s, b2_s, a1_s, a2_s;
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [RND_W-1:0]  rnd_s;

    assign b0_s = coefs[k*5*CWIDTH + 0*CWIDTH +: CWIDTH];
    assign b1_s = coefs[k*5*CWIDTH + 1*CWIDTH +: CWIDTH];
    assign b2_s = coefs[k*5*CWIDTH + 2*CWIDTH +: CWIDTH];
    assign a1_s = coefs[k*5*CWIDTH + 3*CWIDTH +: CWIDTH];
    assign a2_s = coefs[k*5*CWIDTH + 4*CWIDTH +: CWIDTH];

    if (k == 0) begin : g_head
      assign xin_s[k] = din;
      assign vin_s[k] = din_vld;
    end else begin : g_tail
      assign xin_s[k] = y1_r[k-1];
      assign vin_s[k] = vld_r[k-1];
    end

    // Direct Form I sum at full precision
    always_comb begin
      acc_s = mul(b0_s, xin_s[k]) + mul(b1_s, x1_r[k]) + mul(b2_s, x2_r[k])
            - mul(a1_s, y1_r[k]) - mul(a2_s, y2_r[k]);
    end

    round_handle #(.IW(ACC_W), .SHIFT(SHIFT)) u_round (.acc(acc_s), .rnd(rnd_s));

`ifdef IIR_STAGE_SAT_EN
    sat_handle #(.IW(RND_W), .OW(DWIDTH)) u_sat (.din(rnd_s), .dout(yn_s[k]));
`else
    logic unused_rnd_s;
    assign unused_rnd_s = ^rnd_s[RND_W-1:DWIDTH];
    assign yn_s[k]      = rnd_s[DWIDTH-1:0];
`endif
  end

  // history and valid-token pipeline; y1 doubles as each stage's output register
  always_ff @(posedge clk) begin
    for (int k = 0; k < CASCADE_LEVEL; k++) begin
      if (rstn || !block_en) begin
        x1_r[k]  <= '0;
        x2_r[k]  <= '0;
        y1_r[k]  <= '0;
        y2_r[k]  <= '0;
        vld_r[k] <= 1'b0;
      end else begin
        vld_r[k] <= vin_s[k];
        if (vin_s[k]) begin
          x1_r[k] <= xin_s[k];
          x2_r[k] <= x1_r[k];
          y1_r[k] <= yn_s[k];
          y2_r[k] <= y1_r[k];
        end
      end
    end
  end

  assign dout         = y1_r[CASCADE_LEVEL-1];
  assign unused_vld_s = vld_r[CASCADE_LEVEL-1];
endmodule

// File: tb/tb_iir_cascade.sv
// Directed and randomized bench for iir_cascade against an arithmetic cascade model.

module tb_iir_cascade;
  localparam int L  = 2;
  localparam int DW = 24;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              block_en;
  logic [L*5*CW-1:0] coefs;
  logic              din_vld;
  logic [DW-1:0]     din;
  logic [DW-1:0]     dout;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    int          due;
    logic [23:0] val;
  } exp_t;
  exp_t        exp_q[$];
  logic [23:0] mdl_dout;
  int          cf[L][5];
  longint      hx1[L], hx2[L], hy1[L], hy2[L];

  iir_cascade #(.CASCADE_LEVEL(L), .DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .block_en(block_en), .coefs(coefs),
    .din_vld(din_vld), .din(din), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic longint shape(input longint acc);
    longint r;
    r = (acc + 64'sd8192) >>> 14;
`ifdef IIR_STAGE_SAT_EN
    if (r > 64'sd8388607) r = 64'sd8388607;
    if (r < -64'sd8388608) r = -64'sd8388608;
`else
    r = r & 64'sh00FFFFFF;
    if (r >= 64'sd8388608) r = r - 64'sd16777216;
`endif
    return r;
  endfunction

  function automatic logic [23:0] cascade(input longint x);
    longint xi, acc, y;
    xi = x;
    for (int k = 0; k < L; k++) begin
      acc = longint'(cf[k][0]) * xi + longint'(cf[k][1]) * hx1[k] + longint'(cf[k][2]) * hx2[k]
          - longint'(cf[k][3]) * hy1[k] - longint'(cf[k][4]) * hy2[k];
      y = shape(acc);
      hx2[k] = hx1[k]; hx1[k] = xi;
      hy2[k] = hy1[k]; hy1[k] = y;
      xi = y;
    end
    return xi[23:0];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < L; k++) begin
      hx1[k] = 0; hx2[k] = 0; hy1[k] = 0; hy2[k] = 0;
    end
    exp_q.delete();
    mdl_dout = 24'd0;
  endtask

  task automatic set_coefs();
    for (int k = 0; k < L; k++)
      for (int j = 0; j < 5; j++)
        coefs[k*5*CW + j*CW +: CW] = cf[k][j][CW-1:0];
  endtask

  task automatic zero_coefs();
    for (int k = 0; k < L; k++)
      for (int j = 0; j < 5; j++)
        cf[k][j] = 0;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic step(input logic v, input logic [23:0] d);
    exp_t e;
    din_vld = v;
    din     = d;
    @(posedge clk);
    edge_n++;
    if (rstn || !block_en) begin
      clear_model();
    end else begin
      if (v) begin
        e.due = edge_n + L - 1;
        e.val = cascade(longint'($signed(d)));
        exp_q.push_back(e);
      end
      while (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
        mdl_dout = exp_q[0].val;
        void'(exp_q.pop_front());
      end
    end
    #1;
    check("model_dout", dout, mdl_dout);
  endtask

  task automatic flush();
    block_en = 1'b0;
    step(1'b0, 24'd0);
    block_en = 1'b1;
  endtask

  task automatic recursion_coefs();
    zero_coefs();
    cf[0][0] = 16384; cf[0][3] = -8192; cf[1][0] = 16384;
    set_coefs();
  endtask

  initial begin
    rstn = 1'b1; block_en = 1'b1; din_vld = 1'b0; din = 24'd0; coefs = '0;
    clear_model();
    zero_coefs();

    // reset
    step(1'b0, 24'd0);
    step(1'b1, 24'd123);
    check("reset_dout", dout, 24'd0);
    rstn = 1'b0;

    // passthrough
    cf[0][0] = 16384; cf[1][0] = 16384; set_coefs();
    step(1'b1, 24'd1000);
    check("pass_latency", dout, 24'd0);
    step(1'b0, 24'd0);
    check("pass_1000", dout, 24'd1000);
    step(1'b0, 24'd0);
    check("pass_hold", dout, 24'd1000);

    // recursion, back-to-back strobes
    flush();
    recursion_coefs();
    step(1'b1, 24'd1000);
    step(1'b1, 24'd0);
    check("rec_1000", dout, 24'd1000);
    step(1'b1, 24'd0);
    check("rec_500", dout, 24'd500);
    step(1'b1, 24'd0);
    check("rec_250", dout, 24'd250);
    step(1'b0, 24'd0);
    check("rec_125", dout, 24'd125);

    // rounding
    flush();
    zero_coefs(); cf[0][0] = 8192; cf[1][0] = 16384; set_coefs();
    step(1'b1, 24'd3);
    step(1'b1, 24'hFFFFFD);
    check("round_pos", dout, 24'd2);
    step(1'b0, 24'd0);
    check("round_neg", dout, 24'hFFFFFF);

    // overflow
    flush();
    zero_coefs(); cf[0][0] = 32767; cf[1][0] = 16384; set_coefs();
    step(1'b1, 24'h7FFFFF);
    step(1'b1, 24'h800000);
`ifdef IIR_STAGE_SAT_EN
    check("sat_pos", dout, 24'h7FFFFF);
`else
    check("wrap_pos", dout, 24'hFFFDFE);
`endif
    step(1'b0, 24'd0);
`ifdef IIR_STAGE_SAT_EN
    check("sat_neg", dout, 24'h800000);
`else
    check("wrap_neg", dout, 24'h000200);
`endif

    // reset mid-operation, then no residue
    flush();
    recursion_coefs();
    step(1'b1, 24'd1000);
    step(1'b1, 24'd0);
    step(1'b0, 24'd0);
    check("ctl_hist", dout, 24'd500);
    rstn = 1'b1;
    step(1'b1, 24'd9);
    check("ctl_rst_zero", dout, 24'd0);
    rstn = 1'b0;
    step(1'b1, 24'd5);
    step(1'b0, 24'd0);
    check("ctl_rst_residue", dout, 24'd5);

    // block_en drop mid-pipeline
    step(1'b1, 24'd1000);
    block_en = 1'b0;
    step(1'b1, 24'd77);
    check("ctl_dis_zero", dout, 24'd0);
    step(1'b1, 24'd77);
    check("ctl_dis_ignore", dout, 24'd0);
    block_en = 1'b1;
    step(1'b0, 24'd0);
    check("ctl_dis_discard", dout, 24'd0);
    step(1'b1, 24'd5);
    step(1'b0, 24'd0);
    check("ctl_en_residue", dout, 24'd5);

    // randomized traffic; coefficients change only once the pipeline has drained
    for (int blk = 0; blk < 6; blk++) begin
      step(1'b0, 24'd0);
      step(1'b0, 24'd0);
      for (int k = 0; k < L; k++)
        for (int j = 0; j < 5; j++)
          cf[k][j] = (blk % 2 == 0) ? int'($urandom_range(0, 16383)) - 8192
                                    : int'($urandom_range(0, 65535)) - 32768;
      set_coefs();
      for (int n = 0; n < 60; n++) begin
        block_en = ($urandom_range(0, 39) != 0);
        if (blk % 2 == 0)
          step($urandom_range(0, 3) != 0, 24'(int'($urandom_range(0, 4000)) - 2000));
        else
          step($urandom_range(0, 3) != 0, 24'($urandom));
      end
      block_en = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
